// File: rtl/matrix_reader.sv
// matrix_reader: sweeps a contiguous range of the matrix ROM and streams
// the words out on a valid/ready port with address tags and an XOR checksum.
module matrix_reader #(
    parameter int AW = 10,
    parameter int DW = 39
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW:0]   count,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [AW:0]   remaining;
    logic          load;

    assign rom_addr = addr_q;
    // the output register may refill in the same cycle its word is taken
    assign load = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        checksum <= '0;
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr_q    <= start_addr;
                            remaining <= (count > DEPTH) ? DEPTH : count;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (load) begin
                        out_data  <= rom_data;
                        out_addr  <= addr_q;
                        out_valid <= 1'b1;
                        out_last  <= (remaining == ONE);
                        checksum  <= checksum ^ rom_data;
                        addr_q    <= addr_q + 1'b1;
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_reader.sv
// Directed bench for matrix_reader: sweeps, wrap, backpressure,
// zero/clamped counts, start-while-busy and mid-sweep reset.
module tb_matrix_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  start_addr;
    logic [10:0] count;
    logic [9:0]  rom_addr;
    logic [38:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [38:0] out_data;
    logic [9:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [38:0] checksum;

    int checks = 0;
    int errors = 0;

    matrix_reader #(.AW(10), .DW(39)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .start_addr(start_addr),
        .count(count),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_addr(out_addr),
        .out_last(out_last),
        .busy(busy),
        .done(done),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    function automatic logic [38:0] expw(input logic [9:0] a);
        return {29'h0, a} ^ 39'h5A5A5A5A5A;
    endfunction

    assign rom_data = expw(rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input logic [9:0] sa, input logic [10:0] cnt,
                         input int n, input bit poke);
        logic [9:0]  a;
        logic [38:0] cs;
        a  = sa;
        cs = '0;
        start      = 1'b1;
        start_addr = sa;
        count      = cnt;
        out_ready  = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("valid_after_start", out_valid, 0);
        for (int i = 0; i < n; i++) begin
            if (poke) begin
                start      = (i < 2);
                start_addr = 10'd500;
                count      = 11'd5;
            end
            tick();
            chk("valid", out_valid, 1);
            chk("addr", out_addr, a);
            chk("data", out_data, expw(a));
            chk("last", out_last, i == n - 1);
            chk("done_during_run", done, 0);
            cs ^= expw(a);
            a++;
        end
        start = 1'b0;
        tick();
        chk("valid_after_last", out_valid, 0);
        chk("done_pulse", done, 1);
        chk("busy_after_last", busy, 0);
        chk("checksum", checksum, cs);
        tick();
        chk("done_clear", done, 0);
        chk("checksum_hold", checksum, cs);
    endtask

    initial begin
        logic [9:0]  ha;
        logic [38:0] hd;
        logic        hl;
        logic        pat [6];
        int          hs;
        logic [9:0]  next_a;

        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        sweep(10'd0, 11'd4, 4, 1'b0);
        chk("basic_checksum_zero", checksum, 0);

        sweep(10'd1022, 11'd3, 3, 1'b0);

        // backpressure: ready pattern 0,0,1,0,1,1 after first word appears
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        start      = 1'b1;
        start_addr = 10'd5;
        count      = 11'd3;
        out_ready  = 1'b0;
        tick();
        start = 1'b0;
        tick();
        chk("bp_first_valid", out_valid, 1);
        hs     = 0;
        next_a = 10'd5;
        for (int k = 0; k < 6; k++) begin
            out_ready = pat[k];
            ha = out_addr;
            hd = out_data;
            hl = out_last;
            if (out_valid && out_ready) begin
                chk("bp_hs_addr", out_addr, next_a);
                chk("bp_hs_last", out_last, next_a == 10'd7);
                hs++;
                next_a++;
            end
            tick();
            if (!pat[k]) begin
                chk("bp_hold_addr", out_addr, ha);
                chk("bp_hold_data", out_data, hd);
                chk("bp_hold_last", out_last, hl);
                chk("bp_hold_valid", out_valid, 1);
            end
        end
        chk("bp_handshakes", hs, 3);
        chk("bp_done", done, 1);
        chk("bp_valid_off", out_valid, 0);
        chk("bp_checksum", checksum,
            expw(10'd5) ^ expw(10'd6) ^ expw(10'd7));
        out_ready = 1'b1;
        tick();

        start      = 1'b1;
        start_addr = 10'd9;
        count      = 11'd0;
        tick();
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_valid", out_valid, 0);
        chk("zero_busy", busy, 0);
        chk("zero_checksum", checksum, 0);
        tick();
        chk("zero_done_clear", done, 0);
        chk("zero_valid_still", out_valid, 0);

        sweep(10'd7, 11'd2047, 1024, 1'b0);

        sweep(10'd100, 11'd3, 3, 1'b1);

        start      = 1'b1;
        start_addr = 10'd10;
        count      = 11'd8;
        out_ready  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("rst_mid_w0", out_addr, 10);
        tick();
        chk("rst_mid_w1", out_addr, 11);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_addr", out_addr, 0);
        chk("mid_rst_rom_addr", rom_addr, 0);
        chk("mid_rst_checksum", checksum, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", done, 0);
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
